// File: rtl/axi_core_master.sv
// -----------------------------------------------------------------------------
// axi_core_master
//
// Single-outstanding AXI4 master bridge. It turns one core load/store request
// into one single-beat AXI transaction. Loads use the AR/R channels and stores
// use the AW/W/B channels. Read data, a completion pulse and error status are
// returned to the core.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   core_req/we/addr/      core request. The core holds it stable until
//   wdata/wstrb            core_done.
//   core_stall             core must hold its request (core_req & ~core_done)
//   core_done              one-cycle completion pulse
//   core_rdata             registered load data, kept across stores
//   core_err               last response was not OKAY, valid with core_done
//   AR*/R*/AW*/W*/B* _M    AXI4 master channels. Widths come from the
//                          AXI_*_BITS macros in AXI_define.svh. Local fallbacks
//                          apply when those macros are not defined.
//
// Parameters
//   MASTER_ID              value driven on ARID_M / AWID_M
//
// Build option
//   AXI_CORE_MASTER_AWW_PARALLEL_EN
//     Defined:   a store presents AW and W together in the StAw state. Each
//                VALID drops after its own handshake, and the bridge moves to
//                StB once both handshakes are done.
//     Undefined: the store runs AW, then W, then B in strict sequence.
// -----------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_core_master #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // core side
    input  logic                      core_req,
    input  logic                      core_we,
    input  logic [31:0]               core_addr,
    input  logic [31:0]               core_wdata,
    input  logic [3:0]                core_wstrb,
    output logic                      core_stall,
    output logic                      core_done,
    output logic [31:0]               core_rdata,
    output logic                      core_err,
    // AR channel
    output logic [`AXI_ID_BITS-1:0]   ARID_M,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_M,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_M,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE_M,
    output logic [1:0]                ARBURST_M,
    output logic                      ARVALID_M,
    input  logic                      ARREADY_M,
    // R channel
    input  logic [`AXI_ID_BITS-1:0]   RID_M,
    input  logic [`AXI_DATA_BITS-1:0] RDATA_M,
    input  logic [1:0]                RRESP_M,
    input  logic                      RLAST_M,
    input  logic                      RVALID_M,
    output logic                      RREADY_M,
    // AW channel
    output logic [`AXI_ID_BITS-1:0]   AWID_M,
    output logic [`AXI_ADDR_BITS-1:0] AWADDR_M,
    output logic [`AXI_LEN_BITS-1:0]  AWLEN_M,
    output logic [`AXI_SIZE_BITS-1:0] AWSIZE_M,
    output logic [1:0]                AWBURST_M,
    output logic                      AWVALID_M,
    input  logic                      AWREADY_M,
    // W channel
    output logic [`AXI_DATA_BITS-1:0] WDATA_M,
    output logic [`AXI_STRB_BITS-1:0] WSTRB_M,
    output logic                      WLAST_M,
    output logic                      WVALID_M,
    input  logic                      WREADY_M,
    // B channel
    input  logic [`AXI_ID_BITS-1:0]   BID_M,
    input  logic [1:0]                BRESP_M,
    input  logic                      BVALID_M,
    output logic                      BREADY_M
);

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAw,
        StW,
        StB,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // IDs and RLAST carry no information with one transaction in flight.
    logic unused_inputs;
    assign unused_inputs = ^{RID_M, RLAST_M, BID_M};

`ifdef AXI_CORE_MASTER_AWW_PARALLEL_EN
    // These flags record which half of the combined AW+W phase has already
    // handshaken. A finished channel must not present VALID again.
    logic aw_done_q, w_done_q;
    logic aw_hs, w_hs;
    logic aw_ok, w_ok;

    assign aw_hs = AWVALID_M & AWREADY_M;
    assign w_hs  = WVALID_M & WREADY_M;
    assign aw_ok = aw_done_q | aw_hs;
    assign w_ok  = w_done_q | w_hs;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q != StAw) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. VALID is constant in each state, so READY alone
    // completes the handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (core_req) state_d = core_we ? StAw : StAr;
            StAr:   if (ARREADY_M) state_d = StR;
            StR:    if (RVALID_M) state_d = StDone;
`ifdef AXI_CORE_MASTER_AWW_PARALLEL_EN
            StAw:   if (aw_ok && w_ok) state_d = StB;
`else
            StAw:   if (AWREADY_M) state_d = StW;
`endif
            StW:    if (WREADY_M) state_d = StB;
            StB:    if (BVALID_M) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        AWVALID_M = 1'b0;
        WVALID_M  = 1'b0;
        BREADY_M  = 1'b0;
        core_done = 1'b0;
        unique case (state_q)
            StAr:   ARVALID_M = 1'b1;
            StR:    RREADY_M  = 1'b1;
`ifdef AXI_CORE_MASTER_AWW_PARALLEL_EN
            StAw: begin
                AWVALID_M = ~aw_done_q;
                WVALID_M  = ~w_done_q;
            end
`else
            StAw:   AWVALID_M = 1'b1;
`endif
            StW:    WVALID_M  = 1'b1;
            StB:    BREADY_M  = 1'b1;
            StDone: core_done = 1'b1;
            default: ;
        endcase
    end

    // Fixed single-beat, word-sized, INCR fields; payload from the captured request.
    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = '0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = BurstIncr;

    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = '0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = BurstIncr;

    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;
    assign WLAST_M   = 1'b1;

    assign core_stall = core_req & ~core_done;
    assign core_rdata = rdata_q;
    assign core_err   = err_q;

    // Request capture and response capture
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && core_req) begin
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
                wstrb_q <= core_wstrb;
            end
            if (state_q == StR && RVALID_M) begin
                rdata_q <= RDATA_M;
                err_q   <= (RRESP_M != RespOkay);
            end
            if (state_q == StB && BVALID_M) begin
                err_q <= (BRESP_M != RespOkay);
            end
        end
    end

endmodule
